serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 83 ++++++++
 tb/tb_serial_add_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder controller with start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to enable subtraction via the sub input.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, rs, b_ld;
  logic [NW-1:0] n;
  logic c, s, c_nxt, c_ld;
`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_ld = b;
  assign c_ld = cin;
`endif
  always_comb begin
    s = sa[0] ^ sb[0] ^ c;
    c_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      n     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b_ld;
            c     <= c_ld;
            n     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          rs <= {s, rs[WIDTH-1:1]};
          c  <= c_nxt;
          n  <= n + 1'b1;
          if (n == NW'(WIDTH - 1)) begin
            sum   <= {s, rs[WIDTH-1:1]};
            cout  <= c_nxt;
            n     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0] last_res = '0;
  int total = 0, bad = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, y, input logic ci, s);
    logic [WIDTH-1:0] ny;
    ny = ~y;
`ifdef SERIAL_ADD_SUB_EN
    if (s) return {1'b0, x} + {1'b0, ny} + 1;
`endif
    return {1'b0, x} + {1'b0, y} + ci;
  endfunction

  task automatic do_add(input logic [WIDTH-1:0] x, y, input logic ci, s, input int poke);
    logic [WIDTH:0] e;
    int nb, nd;
    e = ref_add(x, y, ci, s);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    chk("hold_sum", sum, last_res[WIDTH-1:0]);
    chk("hold_cout", cout, last_res[WIDTH]);
    nb = 0;
    while (!done && nb < WIDTH + 4) begin
      if (busy) nb++;
      if (nb == poke) begin
        start = 1'b1; a = 8'hFF;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_cycles", nb, WIDTH);
    chk("sum", sum, e[WIDTH-1:0]);
    chk("cout", cout, e[WIDTH]);
    last_res = e;
    nd = 0;
    repeat (poke > 0 ? 12 : 1) begin
      @(negedge clk);
      nd += done;
    end
    chk("extra_done", nd, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int cyc, nd;
    logic [WIDTH:0] e;
    logic [WIDTH-1:0] x, y;
    logic ci;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    do_add(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    do_add(8'h5A, 8'hA5, 1'b1, 1'b0, -1);
    do_add(8'h12, 8'h34, 1'b0, 1'b0, -1);
    do_add(8'h00, 8'h00, 1'b0, 1'b0, -1);
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
    do_add(8'h21, 8'h43, 1'b0, 1'b0, 3);

    // back-to-back: start held high, new operands presented in each DONE cycle
    x = $urandom; y = $urandom; ci = $urandom;
    e = ref_add(x, y, ci, 1'b0);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 30);
      chk("b2b_gap", cyc, WIDTH + 1);
      chk("b2b_sum", sum, e[WIDTH-1:0]);
      chk("b2b_cout", cout, e[WIDTH]);
      last_res = e;
      if (k == 5) start = 1'b0;
      else begin
        x = $urandom; y = $urandom; ci = $urandom;
        a = x; b = y; cin = ci;
        e = ref_add(x, y, ci, 1'b0);
      end
    end
    repeat (2) @(negedge clk);

    // reset abort in RUN cycle 4
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += done;
    end
    chk("abort_no_done", nd, 0);
    do_add(8'h03, 8'h04, 1'b0, 1'b0, -1);

`ifdef SERIAL_ADD_SUB_EN
    do_add(8'h10, 8'h01, 1'b0, 1'b1, -1);
    do_add(8'h01, 8'h02, 1'b1, 1'b1, -1);
`endif

    repeat (20) do_add($urandom, $urandom, $urandom, $urandom, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
